// File: rtl/rvj1_defines.sv
// Shared constants for the jedro_1 RAM-side logic: arbiter FSM encodings,
// one-hot grant codes and the default data-RAM window base.
package rvj1_defines;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    // Bit 0 is the CPU, bit 1 the Wishbone slave path.
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_WB   = 2'b10;
    localparam logic [1:0] GRANT_NONE = 2'b00;

    localparam logic [31:0] DEFAULT_BASE_ADDR_RAM = 32'h3000_4000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: masked requests in, one-hot grant out.
// prio_q = 0 lets requester 0 win a tie; each accepted grant hands priority to the other side.
module rr_arbiter2
    import rvj1_defines::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       prio_o
);

    logic       prio_q, prio_d;
    logic [1:0] eff_req;

    always_comb begin
        eff_req = req_i & ~mask_i;
        if (eff_req == 2'b11) begin
            grant_o = prio_q ? GRANT_WB : GRANT_CPU;
        end else begin
            grant_o = eff_req;
        end

        prio_d = prio_q;
        if (advance_i && (grant_o != GRANT_NONE)) begin
            prio_d = grant_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio_o = prio_q;

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the jedro_1 CPU data port and the Wishbone slave,
// one access per grant, fixed two-cycle request-to-ack latency.
module dram_arbiter
    import rvj1_defines::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH_WORDS = 9,
    parameter logic [31:0] BASE_ADDR_RAM        = DEFAULT_BASE_ADDR_RAM
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,

    input  logic                            cpu_stb,
    input  logic [3:0]                      cpu_we,
    input  logic [31:0]                     cpu_addr,
    input  logic [31:0]                     cpu_wdata,
    output logic [31:0]                     cpu_rdata,
    output logic                            cpu_ack,
    output logic                            cpu_err,

    input  logic                            wbs_cyc_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_dat_i,
    input  logic [31:0]                     wbs_adr_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,

    output logic                            ram_clk0,
    output logic                            ram_csb0,
    output logic                            ram_web0,
    output logic [3:0]                      ram_wmask0,
    output logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0,
    output logic [31:0]                     ram_din0,
    input  logic [31:0]                     ram_dout0
);

    localparam int unsigned AW = RAM_ADDR_WIDTH_WORDS;
    localparam logic [32:0] WinLo = {1'b0, BASE_ADDR_RAM};
    localparam logic [32:0] WinHi = WinLo + (33'd1 << (AW + 2));

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic          err_q, err_d;

    logic          cpu_in_win;
    logic          creq, wreq;
    logic [1:0]    arb_mask;
    logic          arb_advance;
    logic [1:0]    arb_grant;
    logic          prio_unused;
    logic          resp_ok;
    logic          addr_bits_unused;

    assign cpu_in_win = ({1'b0, cpu_addr} >= WinLo) && ({1'b0, cpu_addr} < WinHi);
    assign creq       = cpu_stb & cpu_in_win;
    assign wreq       = wbs_cyc_i & wbs_stb_i;

    // The side just served still shows its strobe during RESP, so keep it out of this pick.
    assign arb_mask    = (state_q == StResp) ? grant_q : GRANT_NONE;
    assign arb_advance = (state_q != StAccess);

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .req_i     ({wreq, creq}),
        .mask_i    (arb_mask),
        .advance_i (arb_advance),
        .grant_o   (arb_grant),
        .prio_o    (prio_unused)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = cpu_stb & ~cpu_in_win & ~err_q;

        if (state_q == StAccess) begin
            state_d = StResp;
        end else if (arb_grant == GRANT_CPU) begin
            state_d = StAccess;
            grant_d = GRANT_CPU;
            csb_d   = 1'b0;
            web_d   = ~(|cpu_we);
            wmask_d = (|cpu_we) ? cpu_we : 4'hF;
            addr_d  = cpu_addr[AW+1:2];
            din_d   = cpu_wdata;
        end else if (arb_grant == GRANT_WB) begin
            state_d = StAccess;
            grant_d = GRANT_WB;
            csb_d   = 1'b0;
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'hF;
            addr_d  = wbs_adr_i[AW+1:2];
            din_d   = wbs_dat_i;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            grant_q <= GRANT_NONE;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'h0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the select and acks so an in-flight access is dropped at the reset edge.
    assign resp_ok    = (state_q == StResp) & ~wb_rst_i;
    assign cpu_ack    = resp_ok & (grant_q == GRANT_CPU);
    assign wbs_ack_o  = resp_ok & (grant_q == GRANT_WB);
    assign cpu_rdata  = cpu_ack ? ram_dout0 : 32'h0;
    assign wbs_dat_o  = wbs_ack_o ? ram_dout0 : 32'h0;
    assign cpu_err    = err_q;

    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = csb_q | wb_rst_i;
    assign ram_web0   = web_q;
    assign ram_wmask0 = wmask_q;
    assign ram_addr0  = addr_q;
    assign ram_din0   = din_q;

    assign addr_bits_unused = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: behavioural RAM plus a word-level reference memory,
// randomized traffic checked against arbitration and latency rules.
module tb_dram_arbiter;

    localparam int unsigned AW    = 9;
    localparam int unsigned Words = 512;
    localparam logic [31:0] Base  = 32'h3000_4000;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cpu_stb = 1'b0;
    logic [3:0]    cpu_we = 4'h0;
    logic [31:0]   cpu_addr = 32'h0;
    logic [31:0]   cpu_wdata = 32'h0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ack, cpu_err;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'h0;
    logic [31:0]   wbs_dat_i = 32'h0, wbs_adr_i = 32'h0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          ram_clk0, ram_csb0, ram_web0;
    logic [3:0]    ram_wmask0;
    logic [AW-1:0] ram_addr0;
    logic [31:0]   ram_din0, ram_dout0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [Words];
    logic [31:0] mem [Words];
    logic        do_load = 1'b0;

    always #5 clk = ~clk;

    dram_arbiter #(
        .RAM_ADDR_WIDTH_WORDS (AW),
        .BASE_ADDR_RAM        (Base)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .cpu_stb    (cpu_stb),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ram_clk0   (ram_clk0),
        .ram_csb0   (ram_csb0),
        .ram_web0   (ram_web0),
        .ram_wmask0 (ram_wmask0),
        .ram_addr0  (ram_addr0),
        .ram_din0   (ram_din0),
        .ram_dout0  (ram_dout0)
    );

    // OpenRAM-like port: capture on the rising edge, read data valid the following cycle.
    always @(posedge ram_clk0) begin
        if (do_load) begin
            for (int i = 0; i < Words; i++) mem[i] <= ref_mem[i];
        end else if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask0[b]) mem[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
            end else begin
                ram_dout0 <= mem[ram_addr0];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] word_addr(input int unsigned w);
        return Base + 32'(w * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output logic [AW-1:0] a_seen,
                           output logic e_seen);
        cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_stb = 1'b1;
        rd = 32'h0; lat = -1; a_seen = '0; e_seen = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) a_seen = ram_addr0;
            if (cpu_err) e_seen = 1'b1;
            if (cpu_ack) begin
                rd = cpu_rdata; lat = i;
                break;
            end
        end
        cpu_stb = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_load = 1'b1;
        tick();
        do_load = 1'b0;
        tick();
        n_checks++;
        if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, cpu_ack, wbs_ack_o, cpu_err}
            !== {1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 3'b000})
            $display("FAIL reset_in: got csb=%b web=%b wm=%h a=%h din=%h acks=%b%b err=%b want 1 1 0 0 0 00 0",
                     ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, cpu_ack, wbs_ack_o, cpu_err);
        else n_pass++;
        wb_rst_i = 1'b0;
        tick();
        n_checks++;
        if ({ram_csb0, ram_web0, ram_wmask0, cpu_ack, wbs_ack_o, cpu_err} !== {1'b1, 1'b1, 4'h0, 3'b000})
            $display("FAIL reset_idle: got csb=%b web=%b wm=%h acks=%b%b err=%b want 1 1 0 00 0",
                     ram_csb0, ram_web0, ram_wmask0, cpu_ack, wbs_ack_o, cpu_err);
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        cpu_addr = 32'h3000_4014; cpu_we = 4'h0; cpu_stb = 1'b1;
        tick();
        n_checks++;
        if ({ram_csb0, ram_web0, ram_addr0, cpu_ack} !== {1'b0, 1'b1, 9'd5, 1'b0})
            $display("FAIL cpu_rd_access: got csb=%b web=%b a=%h ack=%b want 0 1 005 0",
                     ram_csb0, ram_web0, ram_addr0, cpu_ack);
        else n_pass++;
        tick();
        n_checks++;
        if ({cpu_ack, ram_csb0, cpu_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF})
            $display("FAIL cpu_rd_ack: got ack=%b csb=%b rdata=%h want 1 1 deadbeef",
                     cpu_ack, ram_csb0, cpu_rdata);
        else n_pass++;
        cpu_stb = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 32'h0})
            $display("FAIL cpu_rd_pulse: got ack=%b rdata=%h want 0 0", cpu_ack, cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_wb_write();
        logic [31:0] rd;
        int          lat;
        logic [AW-1:0] a;
        logic        e;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'b0010; wbs_dat_i = 32'h0000_AB00; wbs_adr_i = 32'h3000_4008;
        tick();
        n_checks++;
        if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0}
            !== {1'b0, 1'b0, 4'b0010, 9'd2, 32'h0000_AB00})
            $display("FAIL wb_wr_access: got csb=%b web=%b wm=%b a=%h din=%h want 0 0 0010 002 0000ab00",
                     ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0);
        else n_pass++;
        tick();
        n_checks++;
        if (wbs_ack_o !== 1'b1) $display("FAIL wb_wr_ack: got %b want 1", wbs_ack_o);
        else n_pass++;
        ref_mem[2] = merge(ref_mem[2], 32'h0000_AB00, 4'b0010);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        tick();
        cpu_txn(32'h3000_4008, 4'h0, 32'h0, rd, lat, a, e);
        n_checks++;
        if ({lat, rd} !== {32'd2, ref_mem[2]})
            $display("FAIL wb_wr_readback: got lat=%0d data=%h want 2 %h", lat, rd, ref_mem[2]);
        else n_pass++;
    endtask

    logic [8:0]  c_word, w_word;
    logic [3:0]  c_we;
    logic [31:0] c_wd;

    task automatic new_cpu_req();
        c_word = 9'($urandom_range(0, Words - 1));
        c_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        c_wd   = $urandom;
        cpu_addr = word_addr(c_word); cpu_we = c_we; cpu_wdata = c_wd; cpu_stb = 1'b1;
    endtask

    task automatic new_wb_req();
        w_word = 9'($urandom_range(0, Words - 1));
        wbs_we_i  = 1'($urandom_range(0, 1));
        wbs_sel_i = 4'($urandom_range(1, 15));
        wbs_dat_i = $urandom;
        wbs_adr_i = word_addr(w_word);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    endtask

    // Both masters keep a request up at all times; the reference expects strict alternation
    // starting with the CPU, one completion every second cycle.
    task automatic test_simultaneous();
        logic exp_cpu;
        int   last, acks;
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        new_cpu_req();
        new_wb_req();
        exp_cpu = 1'b1; last = 0; acks = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            if (cpu_ack && wbs_ack_o) begin
                n_checks++;
                $display("FAIL sim_double_ack: cycle %0d got both acks want one", cyc);
            end else if (cpu_ack || wbs_ack_o) begin
                n_checks++;
                if (cpu_ack !== exp_cpu || (cyc - last) != 2)
                    $display("FAIL sim_order: cycle %0d got cpu_ack=%b gap=%0d want cpu_ack=%b gap=2",
                             cyc, cpu_ack, cyc - last, exp_cpu);
                else n_pass++;
                if (cpu_ack) begin
                    if (c_we == 4'h0) begin
                        n_checks++;
                        if (cpu_rdata !== ref_mem[c_word])
                            $display("FAIL sim_cpu_rdata: got %h want %h", cpu_rdata, ref_mem[c_word]);
                        else n_pass++;
                    end else begin
                        ref_mem[c_word] = merge(ref_mem[c_word], c_wd, c_we);
                    end
                    new_cpu_req();
                end else begin
                    if (!wbs_we_i) begin
                        n_checks++;
                        if (wbs_dat_o !== ref_mem[w_word])
                            $display("FAIL sim_wb_rdata: got %h want %h", wbs_dat_o, ref_mem[w_word]);
                        else n_pass++;
                    end else begin
                        ref_mem[w_word] = merge(ref_mem[w_word], wbs_dat_i, wbs_sel_i);
                    end
                    new_wb_req();
                end
                exp_cpu = ~exp_cpu; last = cyc; acks++;
            end
        end
        n_checks++;
        if (acks != 8) $display("FAIL sim_count: got %0d accesses want 8", acks);
        else n_pass++;
        cpu_stb = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_err();
        int errs, cacks, wlat;
        logic [31:0] wdat;
        cpu_addr = 32'h3000_0000; cpu_we = 4'h0; cpu_stb = 1'b1;
        tick();
        n_checks++;
        if ({cpu_err, ram_csb0, cpu_ack} !== 3'b110)
            $display("FAIL err_pulse: got err=%b csb=%b ack=%b want 1 1 0", cpu_err, ram_csb0, cpu_ack);
        else n_pass++;
        tick();
        n_checks++;
        if ({cpu_err, ram_csb0, cpu_ack} !== 3'b010)
            $display("FAIL err_no_reflag: got err=%b csb=%b ack=%b want 0 1 0", cpu_err, ram_csb0, cpu_ack);
        else n_pass++;
        cpu_stb = 1'b0;
        tick();
        // Out-of-window CPU request above the window alongside a WB read.
        cpu_addr = Base + 32'h800 + 32'($urandom_range(0, 255) * 4); cpu_stb = 1'b1;
        w_word = 9'($urandom_range(0, Words - 1));
        wbs_adr_i = word_addr(w_word); wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        errs = 0; cacks = 0; wlat = -1; wdat = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (cpu_err) begin errs++; cpu_stb = 1'b0; end
            if (cpu_ack) cacks++;
            if (wbs_ack_o && wlat < 0) begin
                wlat = i; wdat = wbs_dat_o;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
        end
        n_checks++;
        if (errs != 1 || cacks != 0)
            $display("FAIL err_with_wb: got err pulses=%0d cpu acks=%0d want 1 0", errs, cacks);
        else n_pass++;
        n_checks++;
        if (wlat != 2 || wdat !== ref_mem[w_word])
            $display("FAIL err_wb_unaffected: got lat=%0d data=%h want 2 %h", wlat, wdat, ref_mem[w_word]);
        else n_pass++;
        cpu_stb = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned k;
        int clat, wlat;
        logic [31:0] cdat, wdat;
        k = $urandom_range(0, Words - 1);
        cpu_addr = word_addr(k); cpu_we = 4'hF; cpu_wdata = ~ref_mem[k]; cpu_stb = 1'b1;
        tick();
        wb_rst_i = 1'b1;
        #1;
        n_checks++;
        if (ram_csb0 !== 1'b1) $display("FAIL rst_mid_select: got csb=%b want 1", ram_csb0);
        else n_pass++;
        tick();
        n_checks++;
        if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, cpu_ack, wbs_ack_o, cpu_err}
            !== {1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 3'b000})
            $display("FAIL rst_mid_values: got csb=%b web=%b wm=%h a=%h din=%h acks=%b%b err=%b want reset values",
                     ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, cpu_ack, wbs_ack_o, cpu_err);
        else n_pass++;
        wb_rst_i = 1'b0; cpu_stb = 1'b0;
        tick();
        n_checks++;
        if (cpu_ack !== 1'b0) $display("FAIL rst_mid_no_ack: got %b want 0", cpu_ack);
        else n_pass++;
        // prio is back to CPU, and the dropped write never reached the RAM.
        cpu_addr = word_addr(k); cpu_we = 4'h0; cpu_stb = 1'b1;
        w_word = 9'($urandom_range(0, Words - 1));
        wbs_adr_i = word_addr(w_word); wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        clat = -1; wlat = -1; cdat = 32'h0; wdat = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (cpu_ack && clat < 0) begin clat = i; cdat = cpu_rdata; cpu_stb = 1'b0; end
            if (wbs_ack_o && wlat < 0) begin
                wlat = i; wdat = wbs_dat_o; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
        end
        n_checks++;
        if (clat != 2 || cdat !== ref_mem[k])
            $display("FAIL rst_mid_cpu_after: got lat=%0d data=%h want 2 %h", clat, cdat, ref_mem[k]);
        else n_pass++;
        n_checks++;
        if (wlat != 4 || wdat !== ref_mem[w_word])
            $display("FAIL rst_mid_wb_after: got lat=%0d data=%h want 4 %h", wlat, wdat, ref_mem[w_word]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          lat;
        logic [AW-1:0] a;
        logic        e;
        cpu_txn(word_addr(0), 4'h0, 32'h0, rd, lat, a, e);
        n_checks++;
        if ({lat, a, e, rd} !== {32'd2, 9'h000, 1'b0, ref_mem[0]})
            $display("FAIL b2b_word0: got lat=%0d a=%h err=%b data=%h want 2 000 0 %h",
                     lat, a, e, rd, ref_mem[0]);
        else n_pass++;
        cpu_txn(word_addr(511), 4'h0, 32'h0, rd, lat, a, e);
        n_checks++;
        if ({lat, a, e, rd} !== {32'd2, 9'h1FF, 1'b0, ref_mem[511]})
            $display("FAIL b2b_word511: got lat=%0d a=%h err=%b data=%h want 2 1ff 0 %h",
                     lat, a, e, rd, ref_mem[511]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < Words; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'hDEAD_BEEF;
        test_reset();
        test_cpu_read();
        test_wb_write();
        test_simultaneous();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
